// File: rtl/adder_chk_pkg.sv
// Shared types and default widths for the adder response checker.
package adder_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int VEC_CNT_W   = 32;
  localparam int DEF_N       = 32;
  localparam int DEF_NUM_VEC = 0;
  localparam int DEF_ERR_W   = 16;

endpackage

// File: rtl/adder_ref_model.sv
// Golden N+1-bit sum for one {c_in,a,b} vector; purely combinational.
module adder_ref_model #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N:0]   sum
);

  // Carry-out lands in the extra MSB, so nothing is truncated.
  assign sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/adder_resp_checker.sv
// Response checker for an N-bit adder: 2-stage compare pipeline, run FSM,
// vector/error counters and first-failure capture.
module adder_resp_checker
  import adder_chk_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int NUM_VEC = DEF_NUM_VEC,
  parameter int ERR_W   = DEF_ERR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 chk_valid,
  input  logic [N-1:0]         chk_a,
  input  logic [N-1:0]         chk_b,
  input  logic                 chk_c_in,
  input  logic [N-1:0]         dut_sum,
  input  logic                 dut_c_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [VEC_CNT_W-1:0] vec_cnt,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [2*N:0]         fail_vec,
  output logic [N:0]           fail_res
);

  localparam bit                   LIMITED   = (NUM_VEC != 0);
  localparam logic [VEC_CNT_W-1:0] NUM_VEC_L = VEC_CNT_W'(NUM_VEC);

  state_t               state, state_nxt;
  logic [VEC_CNT_W-1:0] acc_cnt;
  logic                 accept;
  logic                 start_ok;
  logic                 fail_flag;

  logic                 s1_vld;
  logic [2*N:0]         s1_vec;
  logic [N:0]           s1_res;
  logic                 s2_vld;
  logic                 s2_mis;
  logic [2*N:0]         s2_vec;
  logic [N:0]           s2_res;
  logic [N:0]           exp_sum;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign accept   = chk_valid && (state == RUN) && (!LIMITED || (acc_cnt < NUM_VEC_L));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (stop || (LIMITED && (acc_cnt == NUM_VEC_L))) state_nxt = DRAIN;
      DRAIN:   if (!s1_vld && !s2_vld) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  adder_ref_model #(.N(N)) u_ref (
    .a    (s1_vec[2*N-1:N]),
    .b    (s1_vec[N-1:0]),
    .c_in (s1_vec[2*N]),
    .sum  (exp_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_vec <= '0;
      s1_res <= '0;
      s2_vld <= 1'b0;
      s2_mis <= 1'b0;
      s2_vec <= '0;
      s2_res <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_vec <= {chk_c_in, chk_a, chk_b};
        s1_res <= {dut_c_out, dut_sum};
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_vec <= s1_vec;
        s2_res <= s1_res;
        s2_mis <= (exp_sum != s1_res);
      end
    end
  end

  // start is only honoured with an empty pipeline, so clearing here never drops a result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt   <= '0;
      vec_cnt   <= '0;
      err_cnt   <= '0;
      fail_flag <= 1'b0;
      fail_vec  <= '0;
      fail_res  <= '0;
    end else if (start_ok) begin
      acc_cnt   <= '0;
      vec_cnt   <= '0;
      err_cnt   <= '0;
      fail_flag <= 1'b0;
      fail_vec  <= '0;
      fail_res  <= '0;
    end else begin
      if (accept) acc_cnt <= acc_cnt + VEC_CNT_W'(1);
      if (s2_vld) begin
        vec_cnt <= vec_cnt + VEC_CNT_W'(1);
        if (s2_mis) begin
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
          if (!fail_flag) begin
            fail_flag <= 1'b1;
            fail_vec  <= s2_vec;
            fail_res  <= s2_res;
          end
        end
      end
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_adder_resp_checker.sv
// Directed bench: instance A (N=4, NUM_VEC=512), instance B (N=4, unlimited, ERR_W=2).
module tb_adder_resp_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  op_a = '0, op_b = '0, res_sum = '0;
  logic        op_c = 1'b0, res_c = 1'b0;

  logic        start_a = 0, stop_a = 0, vld_a = 0;
  logic        busy_a, done_a, pass_a;
  logic [31:0] vec_cnt_a;
  logic [15:0] err_cnt_a;
  logic [8:0]  fail_vec_a;
  logic [4:0]  fail_res_a;

  logic        start_b = 0, stop_b = 0, vld_b = 0;
  logic        busy_b, done_b, pass_b;
  logic [31:0] vec_cnt_b;
  logic [1:0]  err_cnt_b;
  logic [8:0]  fail_vec_b;
  logic [4:0]  fail_res_b;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  adder_resp_checker #(.N(4), .NUM_VEC(512), .ERR_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .chk_valid(vld_a),
    .chk_a(op_a), .chk_b(op_b), .chk_c_in(op_c), .dut_sum(res_sum), .dut_c_out(res_c),
    .busy(busy_a), .done(done_a), .pass(pass_a), .vec_cnt(vec_cnt_a),
    .err_cnt(err_cnt_a), .fail_vec(fail_vec_a), .fail_res(fail_res_a));

  adder_resp_checker #(.N(4), .NUM_VEC(0), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .chk_valid(vld_b),
    .chk_a(op_a), .chk_b(op_b), .chk_c_in(op_c), .dut_sum(res_sum), .dut_c_out(res_c),
    .busy(busy_b), .done(done_b), .pass(pass_b), .vec_cnt(vec_cnt_b),
    .err_cnt(err_cnt_b), .fail_vec(fail_vec_b), .fail_res(fail_res_b));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic c, input logic [3:0] av, input logic [3:0] bv,
                         input logic [4:0] res);
    op_c = c; op_a = av; op_b = bv;
    {res_c, res_sum} = res;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) $display("FAIL reset_busy got %b%b exp 00", busy_a, busy_b); else passed++;
    checks++; if (done_a !== 1'b0 || done_b !== 1'b0) $display("FAIL reset_done got %b%b exp 00", done_a, done_b); else passed++;
    checks++; if (pass_a !== 1'b0 || pass_b !== 1'b0) $display("FAIL reset_pass got %b%b exp 00", pass_a, pass_b); else passed++;
    checks++; if (vec_cnt_a !== 32'd0 || err_cnt_a !== 16'd0) $display("FAIL reset_cnt got %0d/%0d exp 0/0", vec_cnt_a, err_cnt_a); else passed++;
    checks++; if (fail_vec_a !== 9'd0 || fail_res_a !== 5'd0) $display("FAIL reset_capture got %h/%h exp 0/0", fail_vec_a, fail_res_a); else passed++;
    #3 rst = 1'b0;
    cyc();
    checks++; if (busy_a !== 1'b0) $display("FAIL idle_no_start got busy %b exp 0", busy_a); else passed++;
  endtask

  task automatic test_exhaustive();
    logic [8:0] v;
    int n;
    start_a = 1; cyc(); start_a = 0;
    checks++; if (busy_a !== 1'b1) $display("FAIL exh_busy got %b exp 1", busy_a); else passed++;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      set_vec(v[8], v[7:4], v[3:0], 5'(v[7:4]) + 5'(v[3:0]) + 5'(v[8]));
      vld_a = 1;
      cyc();
    end
    // Extra vectors past NUM_VEC must not be counted.
    set_vec(0, 4'h1, 4'h1, 5'h00);
    cyc();
    vld_a = 0;
    n = 0;
    while (!done_a && n < 20) begin cyc(); n++; end
    checks++; if (done_a !== 1'b1) $display("FAIL exh_done got %b exp 1", done_a); else passed++;
    checks++; if (pass_a !== 1'b1) $display("FAIL exh_pass got %b exp 1", pass_a); else passed++;
    checks++; if (vec_cnt_a !== 32'd512) $display("FAIL exh_vec_cnt got %0d exp 512", vec_cnt_a); else passed++;
    checks++; if (err_cnt_a !== 16'd0) $display("FAIL exh_err_cnt got %0d exp 0", err_cnt_a); else passed++;
  endtask

  task automatic test_bit0_fault();
    int n;
    start_a = 1; cyc(); start_a = 0;
    checks++; if (vec_cnt_a !== 32'd0 || busy_a !== 1'b1 || done_a !== 1'b0) $display("FAIL restart_a got vec %0d busy %b done %b exp 0 1 0", vec_cnt_a, busy_a, done_a); else passed++;
    set_vec(0, 4'h1, 4'h0, 5'h00); vld_a = 1; cyc();
    set_vec(0, 4'h3, 4'h0, 5'h02); cyc();
    vld_a = 0; stop_a = 1; cyc(); stop_a = 0;
    n = 0;
    while (!done_a && n < 20) begin cyc(); n++; end
    checks++; if (done_a !== 1'b1) $display("FAIL b0_done got %b exp 1", done_a); else passed++;
    checks++; if (err_cnt_a !== 16'd2 || vec_cnt_a !== 32'd2) $display("FAIL b0_counts got %0d/%0d exp 2/2", err_cnt_a, vec_cnt_a); else passed++;
    checks++; if (fail_vec_a !== 9'h010) $display("FAIL b0_fail_vec got %h exp 010", fail_vec_a); else passed++;
    checks++; if (fail_res_a !== 5'h00) $display("FAIL b0_fail_res got %h exp 00", fail_res_a); else passed++;
    checks++; if (pass_a !== 1'b0) $display("FAIL b0_pass got %b exp 0", pass_a); else passed++;
  endtask

  task automatic test_overflow();
    int n;
    start_a = 1; cyc(); start_a = 0;
    set_vec(1, 4'hF, 4'h1, 5'h11); vld_a = 1; cyc();
    set_vec(1, 4'hF, 4'h1, 5'h01); cyc();
    vld_a = 0; cyc();
    checks++; if (vec_cnt_a !== 32'd1 || err_cnt_a !== 16'd0) $display("FAIL ovf_good got %0d/%0d exp 1/0", vec_cnt_a, err_cnt_a); else passed++;
    cyc();
    checks++; if (err_cnt_a !== 16'd1) $display("FAIL ovf_bad_err got %0d exp 1", err_cnt_a); else passed++;
    checks++; if (fail_vec_a !== 9'h1F1 || fail_res_a !== 5'h01) $display("FAIL ovf_capture got %h/%h exp 1f1/01", fail_vec_a, fail_res_a); else passed++;
    stop_a = 1; cyc(); stop_a = 0;
    n = 0;
    while (!done_a && n < 20) begin cyc(); n++; end
    checks++; if (done_a !== 1'b1 || pass_a !== 1'b0) $display("FAIL ovf_end got done %b pass %b exp 1 0", done_a, pass_a); else passed++;
  endtask

  task automatic test_stop_with_valid();
    start_b = 1; cyc(); start_b = 0;
    for (int i = 1; i <= 7; i++) begin
      set_vec(0, 4'(i), 4'h1, 5'(i + 1));
      vld_b = 1;
      stop_b = (i == 7);
      cyc();
    end
    vld_b = 0; stop_b = 0;
    checks++; if (vec_cnt_b !== 32'd5) $display("FAIL stop_latency got %0d exp 5", vec_cnt_b); else passed++;
    cyc();
    checks++; if (done_b !== 1'b0 || busy_b !== 1'b1) $display("FAIL stop_drain1 got done %b busy %b exp 0 1", done_b, busy_b); else passed++;
    cyc();
    checks++; if (done_b !== 1'b0 || vec_cnt_b !== 32'd7) $display("FAIL stop_drain2 got done %b vec %0d exp 0 7", done_b, vec_cnt_b); else passed++;
    cyc();
    checks++; if (done_b !== 1'b1 || pass_b !== 1'b1) $display("FAIL stop_done got done %b pass %b exp 1 1", done_b, pass_b); else passed++;
    checks++; if (vec_cnt_b !== 32'd7 || err_cnt_b !== 2'd0) $display("FAIL stop_counts got %0d/%0d exp 7/0", vec_cnt_b, err_cnt_b); else passed++;
    set_vec(0, 4'h2, 4'h2, 5'h1F); vld_b = 1;
    cyc(); cyc(); cyc();
    vld_b = 0; cyc(); cyc();
    checks++; if (vec_cnt_b !== 32'd7 || err_cnt_b !== 2'd0) $display("FAIL done_discard got %0d/%0d exp 7/0", vec_cnt_b, err_cnt_b); else passed++;
  endtask

  task automatic test_saturation();
    int n;
    start_b = 1; cyc(); start_b = 0;
    checks++; if (vec_cnt_b !== 32'd0 || busy_b !== 1'b1) $display("FAIL sat_start got vec %0d busy %b exp 0 1", vec_cnt_b, busy_b); else passed++;
    set_vec(0, 4'h0, 4'h0, 5'h01); vld_b = 1;
    for (int i = 0; i < 6; i++) cyc();
    vld_b = 0; cyc(); cyc();
    checks++; if (err_cnt_b !== 2'd3 || vec_cnt_b !== 32'd6) $display("FAIL sat_counts got %0d/%0d exp 3/6", err_cnt_b, vec_cnt_b); else passed++;
    start_b = 1; cyc(); start_b = 0;
    checks++; if (err_cnt_b !== 2'd3 || busy_b !== 1'b1) $display("FAIL start_in_run got err %0d busy %b exp 3 1", err_cnt_b, busy_b); else passed++;
    stop_b = 1; cyc(); stop_b = 0;
    n = 0;
    while (!done_b && n < 20) begin cyc(); n++; end
    checks++; if (done_b !== 1'b1 || pass_b !== 1'b0 || err_cnt_b !== 2'd3) $display("FAIL sat_done got done %b pass %b err %0d exp 1 0 3", done_b, pass_b, err_cnt_b); else passed++;
    checks++; if (fail_vec_b !== 9'h000 || fail_res_b !== 5'h01) $display("FAIL sat_capture got %h/%h exp 000/01", fail_vec_b, fail_res_b); else passed++;
    start_b = 1; cyc(); start_b = 0;
    checks++; if (vec_cnt_b !== 32'd0 || err_cnt_b !== 2'd0 || busy_b !== 1'b1 || fail_res_b !== 5'h00) $display("FAIL sat_restart got vec %0d err %0d busy %b res %h exp 0 0 1 00", vec_cnt_b, err_cnt_b, busy_b, fail_res_b); else passed++;
  endtask

  task automatic test_reset_midrun();
    set_vec(0, 4'h5, 4'h6, 5'h0B); vld_b = 1;
    cyc(); cyc(); cyc();
    checks++; if (vec_cnt_b !== 32'd1) $display("FAIL midrun_pre got %0d exp 1", vec_cnt_b); else passed++;
    #3 rst = 1'b1;
    #1;
    checks++; if (busy_b !== 1'b0 || done_b !== 1'b0 || done_a !== 1'b0) $display("FAIL midrun_state got busy %b done %b/%b exp 0 0/0", busy_b, done_b, done_a); else passed++;
    checks++; if (vec_cnt_b !== 32'd0 || err_cnt_b !== 2'd0 || fail_vec_a !== 9'd0) $display("FAIL midrun_clear got %0d/%0d/%h exp 0/0/0", vec_cnt_b, err_cnt_b, fail_vec_a); else passed++;
    vld_b = 0;
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    checks++; if (busy_b !== 1'b0 || vec_cnt_b !== 32'd0) $display("FAIL post_reset got busy %b vec %0d exp 0 0", busy_b, vec_cnt_b); else passed++;
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_bit0_fault();
    test_overflow();
    test_stop_with_valid();
    test_saturation();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
